// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake/control bundle between the 4-stage pipeline datapath and its hazard controller.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       DOF_AA;
    logic [3:0]       DOF_BA;
    logic             DOF_USE_A;
    logic             DOF_USE_B;
    logic [3:0]       EX_DA;
    logic             EX_RW;
    logic [3:0]       WB_DA;
    logic             WB_RW;
    logic             BR_TAKEN;
    logic             MEM_BUSY;
    logic             STALL_IF;
    logic             STALL_DOF;
    logic             BUBBLE_EX;
    logic             FLUSH_DOF;
    logic             PC_LOAD;
    logic             FREEZE;
    logic             MEM_ERR;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;

    modport master (
        output DOF_AA, DOF_BA, DOF_USE_A, DOF_USE_B, EX_DA, EX_RW, WB_DA, WB_RW,
               BR_TAKEN, MEM_BUSY,
        input  STALL_IF, STALL_DOF, BUBBLE_EX, FLUSH_DOF, PC_LOAD, FREEZE, MEM_ERR,
               STALL_CNT, FLUSH_CNT
    );

    modport slave (
        input  DOF_AA, DOF_BA, DOF_USE_A, DOF_USE_B, EX_DA, EX_RW, WB_DA, WB_RW,
               BR_TAKEN, MEM_BUSY,
        output STALL_IF, STALL_DOF, BUBBLE_EX, FLUSH_DOF, PC_LOAD, FREEZE, MEM_ERR,
               STALL_CNT, FLUSH_CNT
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/branch/memory-wait sequencer for the IF-DOF-EX-WB pipeline.
// Controls are combinational from state and inputs; state and perf counters are registered.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int R0_ZERO     = 1
) (
    input logic                   CLK,
    input logic                   RESET_N,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, MWAIT} state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [1:0]        PEN_RELOAD = 2'(BR_PENALTY - 1);

    state_t            state;
    logic [1:0]        pen_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              resume_flush;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic haz;
    logic do_branch;
    logic do_stall;
    logic stall;
    logic bubble;
    logic flush_dof;
    logic pc_load;
    logic freeze;

    function automatic logic dest_hit(input logic rw, input logic [3:0] da, input logic [3:0] r);
        return rw && (da == r) && !((R0_ZERO != 0) && (da == 4'd0));
    endfunction

    assign haz = (bus.DOF_USE_A && (dest_hit(bus.EX_RW, bus.EX_DA, bus.DOF_AA) ||
                                    dest_hit(bus.WB_RW, bus.WB_DA, bus.DOF_AA))) ||
                 (bus.DOF_USE_B && (dest_hit(bus.EX_RW, bus.EX_DA, bus.DOF_BA) ||
                                    dest_hit(bus.WB_RW, bus.WB_DA, bus.DOF_BA)));

    // MEM_BUSY dominates every state; MWAIT drives nothing but FREEZE.
    always_comb begin
        do_branch = 1'b0;
        do_stall  = 1'b0;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush_dof = 1'b0;
        pc_load   = 1'b0;
        freeze    = 1'b0;
        if (RESET_N) begin
            freeze = bus.MEM_BUSY;
            case (state)
                RUN: begin
                    if (!bus.MEM_BUSY) begin
                        if (bus.BR_TAKEN) do_branch = 1'b1;
                        else if (haz)     do_stall  = 1'b1;
                    end
                end
                FLUSH: begin
                    if (!bus.MEM_BUSY) begin
                        flush_dof = 1'b1;
                        bubble    = 1'b1;
                        do_branch = bus.BR_TAKEN;
                    end
                end
                default: ;
            endcase
            if (do_branch) begin
                pc_load   = 1'b1;
                flush_dof = 1'b1;
                bubble    = 1'b1;
            end
            if (do_stall) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= RUN;
            pen_cnt      <= '0;
            wait_cnt     <= '0;
            resume_flush <= 1'b0;
            mem_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (do_branch && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
            case (state)
                RUN, FLUSH: begin
                    if (bus.MEM_BUSY) begin
                        // pen_cnt is left untouched so a suspended flush resumes where it stopped
                        state        <= MWAIT;
                        resume_flush <= (state == FLUSH);
                        wait_cnt     <= WAIT_W'(1);
                        if (MEM_TIMEOUT <= 1) mem_err_q <= 1'b1;
                    end else if (do_branch) begin
                        pen_cnt <= PEN_RELOAD;
                        state   <= (BR_PENALTY > 1) ? FLUSH : RUN;
                    end else if (state == FLUSH) begin
                        pen_cnt <= pen_cnt - 2'd1;
                        if (pen_cnt <= 2'd1) state <= RUN;
                    end
                end
                MWAIT: begin
                    if (bus.MEM_BUSY) begin
                        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt >= WAIT_MAX - 1'b1) mem_err_q <= 1'b1;
                    end else begin
                        state    <= resume_flush ? FLUSH : RUN;
                        wait_cnt <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.STALL_IF  = stall;
    assign bus.STALL_DOF = stall;
    assign bus.BUBBLE_EX = bubble;
    assign bus.FLUSH_DOF = flush_dof;
    assign bus.PC_LOAD   = pc_load;
    assign bus.FREEZE    = freeze;
    assign bus.MEM_ERR   = mem_err_q & RESET_N;
    assign bus.STALL_CNT = stall_cnt_q;
    assign bus.FLUSH_CNT = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two controller configurations driven by shared stimulus and checked every cycle
// against a behavioural model, plus directed literal checks.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] aa, ba, ex_da, wb_da;
    logic       use_a, use_b, ex_rw, wb_rw, br, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  bus1 ();

    assign bus0.DOF_AA = aa;    assign bus1.DOF_AA = aa;
    assign bus0.DOF_BA = ba;    assign bus1.DOF_BA = ba;
    assign bus0.DOF_USE_A = use_a; assign bus1.DOF_USE_A = use_a;
    assign bus0.DOF_USE_B = use_b; assign bus1.DOF_USE_B = use_b;
    assign bus0.EX_DA = ex_da;  assign bus1.EX_DA = ex_da;
    assign bus0.EX_RW = ex_rw;  assign bus1.EX_RW = ex_rw;
    assign bus0.WB_DA = wb_da;  assign bus1.WB_DA = wb_da;
    assign bus0.WB_RW = wb_rw;  assign bus1.WB_RW = wb_rw;
    assign bus0.BR_TAKEN = br;  assign bus1.BR_TAKEN = br;
    assign bus0.MEM_BUSY = busy; assign bus1.MEM_BUSY = busy;

    pipeline_hazard_ctrl #(.CNT_W(16), .BR_PENALTY(2), .MEM_TIMEOUT(255), .R0_ZERO(1)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .bus(bus0.slave));
    pipeline_hazard_ctrl #(.CNT_W(4), .BR_PENALTY(3), .MEM_TIMEOUT(20), .R0_ZERO(0)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .bus(bus1.slave));

    // model configuration per DUT index
    function automatic int p_w(int d);   return (d == 0) ? 16 : 4;   endfunction
    function automatic int p_pen(int d); return (d == 0) ? 2 : 3;    endfunction
    function automatic int p_to(int d);  return (d == 0) ? 255 : 20; endfunction
    function automatic bit p_r0(int d);  return (d == 0);            endfunction

    // model state: remaining flush cycles, memory-wait bookkeeping, event tallies
    int flush_left[2];
    bit waiting[2];
    int busy_len[2];
    bit err[2];
    int stalls[2];
    int flushes[2];
    bit known[2];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_outs(int d);
        if (d == 0)
            return {bus0.STALL_IF, bus0.STALL_DOF, bus0.BUBBLE_EX, bus0.FLUSH_DOF,
                    bus0.PC_LOAD, bus0.FREEZE, bus0.MEM_ERR};
        return {bus1.STALL_IF, bus1.STALL_DOF, bus1.BUBBLE_EX, bus1.FLUSH_DOF,
                bus1.PC_LOAD, bus1.FREEZE, bus1.MEM_ERR};
    endfunction

    function automatic bit writes(int d, bit rw, int da, int r);
        return rw && (da == r) && !(p_r0(d) && da == 0);
    endfunction

    function automatic bit m_haz(int d);
        bit ha = writes(d, ex_rw, ex_da, aa) || writes(d, wb_rw, wb_da, aa);
        bit hb = writes(d, ex_rw, ex_da, ba) || writes(d, wb_rw, wb_da, ba);
        return (use_a && ha) || (use_b && hb);
    endfunction

    function automatic logic [6:0] m_outs(int d);
        bit si = 0, sd = 0, bu = 0, fd = 0, pl = 0, fr = 0, me = 0;
        if (rst_n) begin
            me = err[d];
            fr = busy;
            if (!waiting[d] && !busy) begin
                if (br) begin pl = 1; fd = 1; bu = 1; end
                else if (flush_left[d] > 0) begin fd = 1; bu = 1; end
                else if (m_haz(d)) begin si = 1; sd = 1; bu = 1; end
            end
        end
        return {si, sd, bu, fd, pl, fr, me};
    endfunction

    task automatic m_step(int d);
        int maxc = (1 << p_w(d)) - 1;
        if (!rst_n) begin
            flush_left[d] = 0; waiting[d] = 0; busy_len[d] = 0; err[d] = 0;
            stalls[d] = 0; flushes[d] = 0; known[d] = 1;
        end else if (waiting[d]) begin
            if (busy) begin
                busy_len[d]++;
                if (busy_len[d] >= p_to(d)) err[d] = 1;
            end else begin
                waiting[d] = 0;
                busy_len[d] = 0;
            end
        end else if (busy) begin
            waiting[d] = 1;
            busy_len[d] = 1;
            if (busy_len[d] >= p_to(d)) err[d] = 1;
        end else if (br) begin
            if (flushes[d] < maxc) flushes[d]++;
            flush_left[d] = p_pen(d) - 1;
        end else if (flush_left[d] > 0) begin
            flush_left[d]--;
        end else if (m_haz(d)) begin
            if (stalls[d] < maxc) stalls[d]++;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("outs_dut%0d", d), dut_outs(d), m_outs(d));
            if (known[d]) begin
                chk($sformatf("stall_cnt_dut%0d", d),
                    (d == 0) ? longint'(bus0.STALL_CNT) : longint'(bus1.STALL_CNT), stalls[d]);
                chk($sformatf("flush_cnt_dut%0d", d),
                    (d == 0) ? longint'(bus0.FLUSH_CNT) : longint'(bus1.FLUSH_CNT), flushes[d]);
            end
            m_step(d);
        end
    end

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic ua, input logic ub,
                          input logic [3:0] exd, input logic exw, input logic [3:0] wbd,
                          input logic wbw, input logic brt, input logic bsy);
        aa = a; ba = b; use_a = ua; use_b = ub; ex_da = exd; ex_rw = exw;
        wb_da = wbd; wb_rw = wbw; br = brt; busy = bsy;
    endtask

    task automatic quiet();
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int frz;
        int burst;
        for (int d = 0; d < 2; d++) begin
            flush_left[d] = 0; waiting[d] = 0; busy_len[d] = 0; err[d] = 0;
            stalls[d] = 0; flushes[d] = 0; known[d] = 0;
        end

        // reset held with busy and branch asserted
        rst_n = 1'b0;
        set_in(4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs_dut0", dut_outs(0), 0);
            chk("reset_outs_dut1", dut_outs(1), 0);
            step();
        end
        rst_n = 1'b1;
        quiet();
        @(negedge clk);
        chk("post_reset_outs", dut_outs(0), 0);
        chk("post_reset_stall_cnt", bus0.STALL_CNT, 0);
        chk("post_reset_flush_cnt", bus0.FLUSH_CNT, 0);
        step();

        // RAW hazard from EX, then from WB
        set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("haz_ex_stall", {bus0.STALL_IF, bus0.STALL_DOF, bus0.BUBBLE_EX}, 3'b111);
        step();
        set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("haz_wb_stall", {bus0.STALL_IF, bus0.STALL_DOF, bus0.BUBBLE_EX}, 3'b111);
        step();
        quiet();
        @(negedge clk);
        chk("haz_released", {bus0.STALL_IF, bus0.STALL_DOF, bus0.BUBBLE_EX}, 3'b000);
        chk("stall_cnt_two", bus0.STALL_CNT, 2);
        step();

        // R0 destination
        set_in(4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("r0_zero_no_stall", bus0.STALL_IF, 0);
        chk("r0_plain_stall", bus1.STALL_IF, 1);
        step();

        // taken branch coinciding with a hazard
        set_in(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("br_pc_load", bus0.PC_LOAD, 1);
        chk("br_flush_dof_1", bus0.FLUSH_DOF, 1);
        chk("br_no_stall_1", bus0.STALL_IF, 0);
        step();
        set_in(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("br_pc_load_once", bus0.PC_LOAD, 0);
        chk("br_flush_dof_2", bus0.FLUSH_DOF, 1);
        chk("br_no_stall_2", bus0.STALL_IF, 0);
        step();
        quiet();
        @(negedge clk);
        chk("br_flush_done", bus0.FLUSH_DOF, 0);
        chk("br_flush_cnt", bus0.FLUSH_CNT, 1);
        step();

        // long memory wait
        frz = 0;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus0.FREEZE) frz++;
            if (k == 255) chk("mem_err_before_timeout", bus0.MEM_ERR, 0);
            if (k == 256) chk("mem_err_after_timeout", bus0.MEM_ERR, 1);
            step();
        end
        quiet();
        @(negedge clk);
        chk("freeze_cycles", frz, 300);
        chk("freeze_released", bus0.FREEZE, 0);
        chk("mem_err_sticky", bus0.MEM_ERR, 1);
        step();

        // hazard held 20 cycles: 4-bit counter saturates
        set_in(4'd7, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        quiet();
        @(negedge clk);
        chk("stall_cnt_saturated", bus1.STALL_CNT, 15);
        chk("stall_cnt_wide", bus0.STALL_CNT, 22);
        step();

        // reset in the middle of a flush
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        quiet();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_flush_outs_dut0", dut_outs(0), 0);
        chk("abort_flush_outs_dut1", dut_outs(1), 0);
        chk("abort_flush_cnt", bus0.FLUSH_CNT, 0);
        step();

        // randomized traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            aa    = 4'($urandom_range(0, 3));
            ba    = 4'($urandom_range(0, 3));
            ex_da = 4'($urandom_range(0, 3));
            wb_da = 4'($urandom_range(0, 3));
            use_a = 1'($urandom_range(0, 1));
            use_b = 1'($urandom_range(0, 1));
            ex_rw = 1'($urandom_range(0, 1));
            wb_rw = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 7) == 0);
            if (burst > 0) begin
                busy = 1'b1;
                burst--;
            end else if ($urandom_range(0, 15) == 0) begin
                busy = 1'b1;
                burst = $urandom_range(0, 30);
            end else begin
                busy = 1'b0;
            end
            step();
        end
        quiet();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
